instruction_fetch_memory: RTL and testbench
===========================================

Name: instruction_fetch_memory

Overview:
- Parametrised successor to the single-port instruction memory: a synchronous instruction store with a valid/ready fetch request channel, a valid/ready response channel holding up to two pending responses, and a program-load write port.
- Sits between the PC/fetch stage and decode.
- Adds behaviour the plain memory lacks:
  - back-pressure;
  - flush on branch redirect;
  - address fault detection;
  - address echo;
  - runtime program loading.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- DEPTH, 1024, number of instruction words; need not be a power of two.
- ADDR_WIDTH, 12, byte-address width of fetch requests.
- WADDR_WIDTH, 10, word-address width of the load port.
- NOP_WORD, 32'h00000000, data returned on faulted fetches and after reset.
- INIT_FILE, "", hex file loaded at elaboration; empty string means no preload.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  request can be accepted this cycle.
- req_addr  input  ADDR_WIDTH  byte address of the instruction.
- rsp_valid  output  1  response at head of queue.
- rsp_ready  input  1  consumer takes the head response.
- rsp_data  output  DATA_WIDTH  instruction word.
- rsp_addr  output  ADDR_WIDTH  echo of the request address.
- rsp_fault  output  1  request was misaligned or out of range.
- flush  input  1  discard all pending responses.
- wr_en  input  1  load-port write strobe.
- wr_addr  input  WADDR_WIDTH  word address for load.
- wr_data  input  DATA_WIDTH  word to store.

Behaviour:
- Reset:
  - Clock is clk; reset is synchronous and active-high on rst.
  - While rst is high at a clock edge: occupancy=0, rsp_valid=0, rsp_data=NOP_WORD, rsp_addr=0, rsp_fault=0.
  - req_ready is forced low while rst is high.
  - Memory contents are NOT cleared by reset.
  - Reset mid-operation drops all pending responses.
- Acceptance:
  - A request is accepted at an edge where req_valid && req_ready.
  - req_ready = !rst && !flush && (occupancy < 2).
- Latency:
  - The response to a request accepted at edge N is visible, with rsp_valid=1, in the cycle after edge N.
  - Responses are returned strictly in request order.
- Throughput: with rsp_ready held high, one request is accepted every cycle (occupancy stays at 1).
- Occupancy update per edge: +1 on accept, −1 when rsp_valid && rsp_ready. Simultaneous accept and consume leaves occupancy unchanged.
- Hold rule: while rsp_valid && !rsp_ready, rsp_data, rsp_addr and rsp_fault must remain stable.
- Full: at occupancy=2, req_ready=0. A consume at that edge re-opens req_ready in the next cycle (no same-cycle pass-through).
- Fault:
  - A request is faulted if req_addr[1:0] != 0 or (req_addr >> 2) >= DEPTH.
  - A faulted request is still accepted and occupies a slot.
  - Its response carries rsp_data=NOP_WORD, rsp_fault=1, rsp_addr=req_addr.
  - The memory array is not read for a faulted request.
- Flush:
  - Flush has priority over everything.
  - At an edge with flush=1, occupancy becomes 0, rsp_valid deasserts next cycle, and a request presented in that cycle is not accepted.
  - A consume in the flush cycle is still ignored (the flush clears the queue regardless).
- Load port:
  - On an edge with wr_en=1, mem[wr_addr] <= wr_data.
  - wr_addr >= DEPTH is ignored.
  - Writes are independent of the handshake.
  - Same-edge write and fetch to the same word is read-first: the fetch returns the old word.
- Preload: if INIT_FILE is non-empty, the array is initialised from it at elaboration; otherwise contents are undefined until written.

Test Plan:
- Reset then streaming:
  - Stimulus: preload mem[k]=32'h1000_0000+k for k=0..9; hold rst 2 cycles, then fetch addresses 0,4,…,36 back-to-back with rsp_ready=1.
  - Required: req_ready is 0 during reset; one response per cycle, each 1 cycle after acceptance, data 1000_0000..1000_0009 in order, rsp_fault=0.
- Back-pressure:
  - Stimulus: rsp_ready=0; issue fetches to addresses 0, 4, 8.
  - Required: the first two are accepted, then req_ready=0 and rsp_data holds 1000_0000.
  - Then raise rsp_ready for 1 cycle: head pops and req_ready returns next cycle; the third fetch returns 1000_0002.
- Faults:
  - Stimulus: fetch 0x002 and 0x1000 (DEPTH=1024).
  - Required: both responses have rsp_fault=1, rsp_data=0x00000000, rsp_addr=0x002 and 0x1000 respectively.
- Flush:
  - Stimulus: two responses pending; assert flush together with req_valid and rsp_ready.
  - Required: nothing is accepted and rsp_valid=0 next cycle; a subsequent fetch of 0x008 returns 1000_0002 only.
- Read-first collision:
  - Stimulus: same edge: wr_en, wr_addr=3, wr_data=DEADBEEF, plus fetch of 0x00C.
  - Required: response is 1000_0003; a later fetch of 0x00C returns DEADBEEF.
- Mid-operation reset:
  - Stimulus: assert rst with occupancy=2.
  - Required: next cycle rsp_valid=0 and rsp_data=NOP_WORD; memory still holds DEADBEEF at word 3.

Source files
------------

// File: rtl/instruction_fetch_memory_if.sv
// Fetch request/response channel between the PC/fetch stage and the
// instruction store, including the branch-redirect flush.
interface instruction_fetch_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_fault;
  logic                  flush;

  modport master (
    output req_valid, req_addr, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/instruction_fetch_memory.sv
// Synchronous instruction store with a valid/ready fetch channel, a two-deep
// response queue, address fault detection, flush and a program-load port.
module instruction_fetch_memory #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    WADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = 32'h00000000,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  instruction_fetch_memory_if.slave bus,
  input  logic                   wr_en,
  input  logic [WADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_e;

  occ_e                  state, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] slot_data  [2];
  logic [ADDR_WIDTH-1:0] slot_addr  [2];
  logic                  slot_fault [2];
  logic                  wr_ptr, rd_ptr;
  logic                  ready, accept, pop, rsp_valid;
  logic                  misaligned, rd_in_range, wr_in_range, fault;
  logic [IW-1:0]         rd_idx, wr_idx;

  assign rd_idx     = bus.req_addr[IW+1:2];
  assign wr_idx     = wr_addr[IW-1:0];
  assign misaligned = |bus.req_addr[1:0];
  assign fault      = misaligned || !rd_in_range;

  // Range checks collapse to constant true when the address field cannot
  // exceed DEPTH, keeping the comparators out of the netlist.
  generate
    if (DEPTH >= (1 << (ADDR_WIDTH - 2))) begin : g_rd_full
      assign rd_in_range = 1'b1;
    end else begin : g_rd_chk
      assign rd_in_range = bus.req_addr[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH);
    end
    if (DEPTH >= (1 << WADDR_WIDTH)) begin : g_wr_full
      assign wr_in_range = 1'b1;
    end else begin : g_wr_chk
      assign wr_in_range = wr_addr < WADDR_WIDTH'(DEPTH);
    end
  endgenerate

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_next;
  end

  // Handshake decode and occupancy next-state; flush overrides accept and pop.
  always_comb begin
    state_next = state;
    rsp_valid  = (state != S_EMPTY);
    ready      = !rst && !bus.flush && (state != S_TWO);
    accept     = bus.req_valid && ready;
    pop        = rsp_valid && bus.rsp_ready && !bus.flush;
    if (bus.flush) begin
      state_next = S_EMPTY;
    end else if (accept && !pop) begin
      case (state)
        S_EMPTY: state_next = S_ONE;
        S_ONE:   state_next = S_TWO;
        default: state_next = state;
      endcase
    end else if (pop && !accept) begin
      case (state)
        S_TWO:   state_next = S_ONE;
        S_ONE:   state_next = S_EMPTY;
        default: state_next = state;
      endcase
    end
  end

  // Response slots: the array is read at the accepting edge, so the word
  // captured is the pre-write value when the load port hits the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        slot_data[i]  <= NOP_WORD;
        slot_addr[i]  <= '0;
        slot_fault[i] <= 1'b0;
      end
    end else if (bus.flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) begin
        slot_addr[wr_ptr]  <= bus.req_addr;
        slot_fault[wr_ptr] <= fault;
        if (fault) slot_data[wr_ptr] <= NOP_WORD;
        else       slot_data[wr_ptr] <= mem[rd_idx];
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Program-load port; out-of-range word addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_idx] <= wr_data;
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = slot_data[rd_ptr];
  assign bus.rsp_addr  = slot_addr[rd_ptr];
  assign bus.rsp_fault = slot_fault[rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Bench for instruction_fetch_memory: directed scenarios plus a randomized
// phase, all checked against a queue-based reference model.
module tb_instruction_fetch_memory;

  localparam int          AW    = 13;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h00000000;

  typedef struct packed {
    logic [31:0]   data;
    logic [AW-1:0] addr;
    logic          fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] mem_m [DEPTH];
  exp_t        q [$];

  instruction_fetch_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus_if ();

  instruction_fetch_memory #(
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .WADDR_WIDTH(10),
    .NOP_WORD   (NOP),
    .INIT_FILE  ("")
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic [AW-1:0] a);
    exp_t        e;
    int unsigned w;
    w       = int'(a) >> 2;
    e.addr  = a;
    if (a[1:0] != 2'b00 || w >= DEPTH) begin
      e.fault = 1'b1;
      e.data  = NOP;
    end else begin
      e.fault = 1'b0;
      e.data  = mem_m[w];
    end
    return e;
  endfunction

  // One clock: check outputs against the model, then advance the model at
  // the rising edge using the inputs the DUT saw there.
  task automatic cycle();
    logic exp_ready;
    #1;
    exp_ready = !rst && !bus_if.flush && (q.size() < 2);
    check("req_ready", bus_if.req_ready, exp_ready);
    check("rsp_valid", bus_if.rsp_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("rsp_data",  bus_if.rsp_data,  q[0].data);
      check("rsp_addr",  bus_if.rsp_addr,  q[0].addr);
      check("rsp_fault", bus_if.rsp_fault, q[0].fault);
    end
    @(posedge clk);
    if (rst || bus_if.flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && bus_if.rsp_ready) void'(q.pop_front());
      if (bus_if.req_valid && exp_ready) q.push_back(predict(bus_if.req_addr));
    end
    if (wr_en && int'(wr_addr) < DEPTH) mem_m[wr_addr] = wr_data;
    @(negedge clk);
  endtask

  task automatic fetch(input int a);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = AW'(a);
    cycle();
  endtask

  task automatic drain();
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  initial begin
    rst              = 1'b1;
    wr_en            = 1'b0;
    wr_addr          = '0;
    wr_data          = '0;
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.rsp_ready = 1'b0;
    bus_if.flush     = 1'b0;

    // Power-on reset: first edge clears the queue, second is checked.
    @(posedge clk);
    @(negedge clk);
    check("reset_nop", bus_if.rsp_data, NOP);
    check("reset_addr", bus_if.rsp_addr, '0);
    cycle();
    rst = 1'b0;

    // Program load through the write port.
    for (int k = 0; k < 16; k++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(k);
      wr_data = 32'h1000_0000 + 32'(k);
      cycle();
    end
    wr_en = 1'b0;

    // Back-to-back streaming.
    bus_if.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) fetch(4 * k);
    drain();

    // Back-pressure: two accepted, third stalls until a pop frees a slot.
    bus_if.rsp_ready = 1'b0;
    fetch(0);
    fetch(4);
    fetch(8);
    fetch(8);
    bus_if.rsp_ready = 1'b1;
    fetch(8);
    bus_if.rsp_ready = 1'b0;
    fetch(8);
    bus_if.req_valid = 1'b0;
    cycle();
    drain();

    // Faulted fetches: misaligned and out of range.
    fetch('h002);
    fetch('h1000);
    drain();

    // Flush with a request and a consume in the same cycle.
    bus_if.rsp_ready = 1'b0;
    fetch(0);
    fetch(4);
    bus_if.flush     = 1'b1;
    bus_if.rsp_ready = 1'b1;
    fetch(0);
    bus_if.flush     = 1'b0;
    bus_if.req_valid = 1'b0;
    cycle();
    fetch('h008);
    drain();

    // Read-first collision on word 3.
    wr_en   = 1'b1;
    wr_addr = 10'd3;
    wr_data = 32'hDEADBEEF;
    fetch('h00C);
    wr_en = 1'b0;
    fetch('h00C);
    drain();

    // Reset with both slots occupied; memory contents survive.
    bus_if.rsp_ready = 1'b0;
    fetch(0);
    fetch(4);
    bus_if.req_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_nop", bus_if.rsp_data, NOP);
    bus_if.rsp_ready = 1'b1;
    fetch('h00C);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      int a;
      r = int'($urandom_range(0, 7));
      a = 4 * int'($urandom_range(0, 15));
      if (r == 0) a = a + int'($urandom_range(1, 3));
      if (r == 1) a = 'h1000 + int'($urandom_range(0, 'hFFF));
      bus_if.req_valid = ($urandom_range(0, 3) != 0);
      bus_if.req_addr  = AW'(a);
      bus_if.rsp_ready = ($urandom_range(0, 2) != 0);
      bus_if.flush     = ($urandom_range(0, 15) == 0);
      wr_en            = ($urandom_range(0, 7) == 0);
      wr_addr          = 10'($urandom_range(0, 15));
      wr_data          = $urandom;
      cycle();
    end
    bus_if.flush = 1'b0;
    wr_en        = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
